// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier sequencer.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Four radix-4 digits cover an 8-bit multiplier; the product is 16 bits wide.
  localparam int unsigned NUM_PP = 4;
  localparam int unsigned PROD_W = 16;

  // Booth triplet codes {b[2i+1], b[2i], b[2i-1]}.
  localparam logic [2:0] TripZeroLo = 3'b000;
  localparam logic [2:0] TripPosA0  = 3'b001;
  localparam logic [2:0] TripPosA1  = 3'b010;
  localparam logic [2:0] TripPos2A  = 3'b011;
  localparam logic [2:0] TripNeg2A  = 3'b100;
  localparam logic [2:0] TripNegA0  = 3'b101;
  localparam logic [2:0] TripNegA1  = 3'b110;
  localparam logic [2:0] TripZeroHi = 3'b111;

endpackage

// File: rtl/booth_mult_sequencer_encoder.sv
// Radix-4 Booth digit encoder: maps one multiplier triplet to a 9-bit partial
// product plus a sign bit that completes the two's-complement negation.
module Booth_Encoder
  import booth_pkg::*;
(
  input  logic [2:0] triplet_i,
  input  logic [7:0] a_i,
  output logic [8:0] pp_o,
  output logic       sign_o
);

  logic [8:0] a_ext;
  logic [8:0] a_dbl;

  assign a_ext = {a_i[7], a_i};
  // 2A still fits 9 signed bits, including 2 * -128 = -256.
  assign a_dbl = {a_i, 1'b0};

  // Negatives are emitted as one's complement; sign_o supplies the +1.
  always_comb begin
    pp_o   = '0;
    sign_o = 1'b0;
    unique case (triplet_i)
      TripZeroLo, TripZeroHi: begin
        pp_o   = '0;
        sign_o = 1'b0;
      end
      TripPosA0, TripPosA1: begin
        pp_o   = a_ext;
        sign_o = 1'b0;
      end
      TripPos2A: begin
        pp_o   = a_dbl;
        sign_o = 1'b0;
      end
      TripNeg2A: begin
        pp_o   = ~a_dbl;
        sign_o = 1'b1;
      end
      TripNegA0, TripNegA1: begin
        pp_o   = ~a_ext;
        sign_o = 1'b1;
      end
      default: begin
        pp_o   = '0;
        sign_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/booth_mult_sequencer.sv
// Sequential signed 8x8 multiplier: one radix-4 Booth digit per cycle over
// four RUN cycles, with a valid/ready handshake on both operands and result.
module booth_mult_sequencer
  import booth_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [W-1:0]        a_reg_q, a_reg_d;
  logic [W+1:0]        b_reg_q, b_reg_d;
  logic [PROD_W-1:0]   product_q, product_d;

  logic [3:0]          trip_idx;
  logic [2:0]          triplet;
  logic [2:0]          shamt;
  logic [8:0]          pp;
  logic                pp_sign;
  logic [PROD_W-1:0]   pp_ext;
  logic [PROD_W-1:0]   acc_sum;

  // b_reg holds {b, 0}, so digit cnt reads bits [2*cnt+2 : 2*cnt].
  assign trip_idx = {1'b0, cnt_q, 1'b0};
  assign triplet  = b_reg_q[trip_idx +: 3];
  assign shamt    = {cnt_q, 1'b0};

  Booth_Encoder u_enc (
    .triplet_i (triplet),
    .a_i       (a_reg_q),
    .pp_o      (pp),
    .sign_o    (pp_sign)
  );

  assign pp_ext  = {{(PROD_W - 9){pp[8]}}, pp};
  assign acc_sum = acc_q + (pp_ext << shamt) + ({{(PROD_W - 1){1'b0}}, pp_sign} << shamt);

  // Next-state logic for the FSM, digit counter, operand and result registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_reg_d   = a_reg_q;
    b_reg_d   = b_reg_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_reg_d = a;
          b_reg_d = {b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        if (cnt_q == 2'(NUM_PP - 1)) begin
          // Counter parks at its last value; it is cleared on the next accept.
          product_d = acc_sum;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_reg_q   <= '0;
      b_reg_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_reg_q   <= a_reg_d;
      b_reg_q   <= b_reg_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Self-checking bench for booth_mult_sequencer: directed corner cases plus a
// random sweep, compared against plain signed multiplication.
module tb_booth_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [15:0] product;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  booth_mult_sequencer #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int sx;
    int sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    return 16'(sx * sy);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One full transaction from IDLE; stall = cycles out_ready is held low in DONE.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input int stall,
                        input string tag, input bit full);
    logic [15:0] exp;
    int cyc;
    exp = ref_mul(ta, tbv);
    check({tag, "/ready_idle"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tbv;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      if (full) begin
        check({tag, "/busy_run"}, 32'(busy), 32'd1);
        check({tag, "/ready_run"}, 32'(in_ready), 32'd0);
      end
      // Garbage on the inputs while busy must be ignored.
      in_valid = 1'($urandom_range(0, 1));
      a        = 8'($urandom);
      b        = 8'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "/latency"}, 32'(cyc), 32'd5);
    check({tag, "/product"}, 32'(product), 32'(exp));
    if (full) begin
      check({tag, "/busy_done"}, 32'(busy), 32'd1);
      check({tag, "/ready_done"}, 32'(in_ready), 32'd0);
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "/hold_product"}, 32'(product), 32'(exp));
      check({tag, "/hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "/idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "/idle_ready"}, 32'(in_ready), 32'd1);
    check({tag, "/idle_busy"}, 32'(busy), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    logic [7:0]  ra;
    logic [7:0]  rb;
    int last;
    int nres;
    bit seen;

    // Reset state while rst_n is low.
    #2;
    check("rst/in_ready", 32'(in_ready), 32'd1);
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/product", 32'(product), 32'd0);
    // Release mid-cycle; the first accept happens on the very next edge.
    #21 rst_n = 1'b1;

    run_op(8'd3, 8'd5, 0, "basic", 1'b1);
    check("basic/value", 32'(product), 32'h000F);

    run_op(8'h80, 8'h80, 0, "m128xm128", 1'b1);
    run_op(8'h80, 8'h7F, 0, "m128x127", 1'b1);
    run_op(8'h7F, 8'h7F, 0, "127x127", 1'b1);
    run_op(8'h00, 8'hFF, 0, "0xm1", 1'b1);

    // Back-pressure: result must be held for ten cycles.
    run_op(8'hF9, 8'h06, 10, "stall", 1'b1);

    // Reset during the second RUN cycle discards the operation.
    in_valid = 1'b1;
    a = 8'd5;
    b = 8'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst/out_valid", 32'(out_valid), 32'd0);
    check("midrst/busy", 32'(busy), 32'd0);
    check("midrst/in_ready", 32'(in_ready), 32'd1);
    check("midrst/product", 32'(product), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst/no_result", 32'(seen), 32'd0);
    run_op(8'd2, 8'hFD, 0, "after_rst", 1'b1);
    check("after_rst/value", 32'(product), 32'hFFFA);

    // Continuous offers: only operands presented while in_ready is high count.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    last = -1;
    nres = 0;
    for (int c = 0; c < 24; c++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (in_ready) exp_q.push_back(ref_mul(a, b));
      @(posedge clk); #1;
      if (out_valid) begin
        nres++;
        if (exp_q.size() == 0) begin
          check("burst/unexpected", 32'd1, 32'd0);
        end else begin
          exp_v = exp_q.pop_front();
          check("burst/product", 32'(product), 32'(exp_v));
        end
        if (last >= 0) check("burst/interval", 32'(c - last), 32'd6);
        last = c;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("burst/count", 32'(nres), 32'd4);
    check("burst/end_idle", 32'(in_ready), 32'd1);

    // Random sweep.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, (i % 50 == 0) ? 2 : 0, "sweep", 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
